loop_integrator: RTL
====================

LOOP_INTEGRATOR -- requirements
Module: loop_integrator

Interface
REQ-001 SHALL have parameter ACC_SIZE, default 42, meaning accumulator width in bits; fixed at 42 in this revision.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 2, meaning cycles spent in CLEARING after clear_in.
REQ-003 SHALL have port clk_in  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid_in  input  1  strobe qualifying error_in.
REQ-006 SHALL have port error_in  input  signed 16  error sample.
REQ-007 SHALL have port gain_shift_in  input  5  integral gain as left shift; legal values 0..24.
REQ-008 SHALL have port minval_in, maxval_in  input  signed 16 each  output rail limits.
REQ-009 SHALL have port hold_in  input  1  freeze accumulator (from relock hold_out).
REQ-010 SHALL have port clear_in  input  1  zero accumulator (from relock clear_out).
REQ-011 SHALL have port signal_out  output  signed 16  accumulator [41:26].
REQ-012 SHALL have port railed_out  output  2  bit0 = at lower rail, bit1 = at upper rail (to relock railed_in).
REQ-013 SHALL have port valid_out  output  1  strobe, signal_out updated.

Function
REQ-014 SHALL use a two-stage pipeline. Stage 1 registers scaled = sign-extend42(error_in) <<< min(gain_shift_in, 24) together with valid. Stage 2 accumulates.
REQ-015 SHALL assert valid_out and update signal_out exactly 2 cycles after a valid_in, in RUN state only.
REQ-016 SHALL compute lim_hi = maxval_in <<< 26 and lim_lo = minval_in <<< 26 (42-bit signed). In RUN, acc <= clamp(acc + scaled, lim_lo, lim_hi), with the sum formed at 43 bits so it cannot wrap.
REQ-017 SHALL set railed_out[1] when acc >= lim_hi and railed_out[0] when acc <= lim_lo. The flags are registered alongside acc.
REQ-018 SHALL, when minval_in >= maxval_in, force acc to 0 and railed_out to 2'b11, and suppress valid_out.
REQ-019 SHALL implement states RUN, HELD, CLEARING.
REQ-020 SHALL transition RUN->HELD on hold_in=1. In HELD: acc, signal_out and railed_out are frozen and valid_out=0.
REQ-021 SHALL transition HELD->RUN on the first cycle hold_in=0.
REQ-022 SHALL transition from any state to CLEARING on clear_in=1. In CLEARING: acc=0, railed_out=0, stage-1 valid flushed, valid_out=0, and a counter loads CLEAR_CYCLES.
REQ-023 SHALL exit CLEARING when the counter reaches 0: to HELD if hold_in=1, else to RUN. clear_in reasserted during CLEARING reloads the counter.
REQ-024 SHALL give clear_in priority over hold_in when both are asserted in the same cycle.
REQ-025 SHALL keep the limit check active during HELD: if the limits change and acc lies outside them, acc is clamped on the next edge while the state remains HELD.

Reset
REQ-026 SHALL, on rst_in=1 (asynchronous), set state=RUN, acc=0, stage-1 registers=0, signal_out=0, railed_out=2'b00, valid_out=0, CLEARING counter=0.
REQ-027 SHALL, after rst_in is released, accept valid_in on the first rising edge.

Structure
REQ-028 SHALL place the state encodings (RUN=2'b00, HELD=2'b01, CLEARING=2'b10), the rail shift constant 26 and the gain-shift maximum 24 in the shared servo package, also used by relock.
REQ-029 SHALL be implemented as a single module containing one sub-module, sat_clamp: a combinational 43-to-42-bit clamp that also produces the rail flags.

Verification
REQ-030 Constant ramp: error_in=100, gain_shift_in=10, limits ±32767, valid every cycle -> signal_out increments by 1 every 655–656 cycles; first valid_out appears 2 cycles after the first valid_in.
REQ-031 Upper rail: error_in=32767, gain_shift_in=24, maxval_in=1000 -> signal_out saturates at 1000 with railed_out=2'b10 and never exceeds 1000.
REQ-032 Hold: assert hold_in for 50 cycles mid-ramp -> signal_out is constant and valid_out=0; the ramp resumes on the first cycle after release.
REQ-033 Clear with hold: clear_in and hold_in both asserted while railed at -500 -> acc=0 and railed_out=0 on the next edge; state is HELD after 2 cycles.
REQ-034 Async reset: rst_in asserted between clock edges during saturation -> all outputs are 0 immediately, without waiting for a clock edge.
REQ-035 Bad limits: minval_in=10, maxval_in=10 -> railed_out=2'b11, signal_out=0, valid_out=0.

Source files
------------

// File: rtl/loop_integrator_pkg.sv
// rtl/loop_integrator_pkg.sv - shared servo constants, state encoding and gain limiter
package loop_integrator_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_HELD     = 2'b01,
        ST_CLEARING = 2'b10
    } state_t;

    localparam int          RAIL_SHIFT     = 26;
    localparam logic [4:0]  GAIN_SHIFT_MAX = 5'd24;

    function automatic logic [4:0] limit_gain(input logic [4:0] gain);
        return (gain > GAIN_SHIFT_MAX) ? GAIN_SHIFT_MAX : gain;
    endfunction

endpackage

// File: rtl/loop_integrator_sat_clamp.sv
// rtl/loop_integrator_sat_clamp.sv - combinational W+1 to W bit clamp with rail flags
module sat_clamp #(
    parameter int W = 42
) (
    input  logic signed [W:0]   i_sum,
    input  logic signed [W-1:0] i_lim_lo,
    input  logic signed [W-1:0] i_lim_hi,
    output logic signed [W-1:0] o_value,
    output logic [1:0]          o_railed
);

    logic signed [W:0] w_lo_ext;
    logic signed [W:0] w_hi_ext;

    assign w_lo_ext = $signed({i_lim_lo[W-1], i_lim_lo});
    assign w_hi_ext = $signed({i_lim_hi[W-1], i_lim_hi});

    always_comb begin
        o_value = i_sum[W-1:0];
        if (i_sum > w_hi_ext) begin
            o_value = i_lim_hi;
        end else if (i_sum < w_lo_ext) begin
            o_value = i_lim_lo;
        end
        o_railed[1] = (o_value >= i_lim_hi);
        o_railed[0] = (o_value <= i_lim_lo);
    end

endmodule

// File: rtl/loop_integrator.sv
// rtl/loop_integrator.sv - two-stage clamped integrator with hold/clear control
module loop_integrator
    import loop_integrator_pkg::*;
#(
    parameter int ACC_SIZE     = 42,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               valid_in,
    input  logic signed [15:0] error_in,
    input  logic [4:0]         gain_shift_in,
    input  logic signed [15:0] minval_in,
    input  logic signed [15:0] maxval_in,
    input  logic               hold_in,
    input  logic               clear_in,
    output logic signed [15:0] signal_out,
    output logic [1:0]         railed_out,
    output logic               valid_out
);

    localparam int CW = (CLEAR_CYCLES < 2) ? 1 : $clog2(CLEAR_CYCLES + 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [CW-1:0]              r_cnt;
    logic [CW-1:0]              w_cnt_next;
    logic signed [ACC_SIZE-1:0] r_scaled;
    logic                       r_s1_valid;
    logic signed [ACC_SIZE-1:0] r_acc;
    logic [1:0]                 r_railed;
    logic                       r_valid_out;
    logic signed [ACC_SIZE-1:0] w_err_ext;
    logic signed [ACC_SIZE-1:0] w_lim_lo;
    logic signed [ACC_SIZE-1:0] w_lim_hi;
    logic signed [ACC_SIZE-1:0] w_addend;
    logic signed [ACC_SIZE:0]   w_sum;
    logic signed [ACC_SIZE-1:0] w_clamped;
    logic [1:0]                 w_railed;
    logic                       w_bad_limits;
    logic                       w_clear_now;
    logic                       w_accumulate;

    assign w_err_ext    = ACC_SIZE'(error_in);
    assign w_lim_lo     = ACC_SIZE'(minval_in) <<< RAIL_SHIFT;
    assign w_lim_hi     = ACC_SIZE'(maxval_in) <<< RAIL_SHIFT;
    assign w_bad_limits = (minval_in >= maxval_in);
    assign w_clear_now  = clear_in || (r_state == ST_CLEARING);
    assign w_accumulate = (r_state == ST_RUN) && !hold_in;

    // Outside an accumulating cycle the clamp still runs with a zero addend so
    // that limit changes pull a frozen accumulator back inside the rails.
    assign w_addend = (w_accumulate && r_s1_valid) ? r_scaled : '0;
    assign w_sum    = (ACC_SIZE+1)'(r_acc) + (ACC_SIZE+1)'(w_addend);

    sat_clamp #(.W(ACC_SIZE)) u_sat_clamp (
        .i_sum    (w_sum),
        .i_lim_lo (w_lim_lo),
        .i_lim_hi (w_lim_hi),
        .o_value  (w_clamped),
        .o_railed (w_railed)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (clear_in) begin
            w_state_next = ST_CLEARING;
            w_cnt_next   = CW'(CLEAR_CYCLES);
        end else begin
            case (r_state)
                ST_RUN:  if (hold_in)  w_state_next = ST_HELD;
                ST_HELD: if (!hold_in) w_state_next = ST_RUN;
                ST_CLEARING: begin
                    if (r_cnt <= CW'(1)) begin
                        w_cnt_next   = '0;
                        w_state_next = hold_in ? ST_HELD : ST_RUN;
                    end else begin
                        w_cnt_next = r_cnt - CW'(1);
                    end
                end
                default: w_state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_scaled   <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_scaled   <= w_err_ext <<< limit_gain(gain_shift_in);
            r_s1_valid <= valid_in && !w_clear_now;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_acc       <= '0;
            r_railed    <= 2'b00;
            r_valid_out <= 1'b0;
        end else if (w_clear_now) begin
            r_acc       <= '0;
            r_railed    <= 2'b00;
            r_valid_out <= 1'b0;
        end else if (w_bad_limits) begin
            r_acc       <= '0;
            r_railed    <= 2'b11;
            r_valid_out <= 1'b0;
        end else begin
            r_acc       <= w_clamped;
            r_railed    <= w_railed;
            r_valid_out <= w_accumulate && r_s1_valid;
        end
    end

    assign signal_out = r_acc[ACC_SIZE-1 -: 16];
    assign railed_out = r_railed;
    assign valid_out  = r_valid_out;

endmodule
